// File: rtl/imem_boot_ctrl.sv
// Boot/load controller for the 256-word instruction memory: streams bytes into
// little-endian words, writes them sequentially, then releases the core to fetch.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [31:0]       PC_Out,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] imem_raddr,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              err_q, err_d;

  logic              byte_ready_q, byte_ready_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic              imem_we_q, imem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;

  logic              byte_fire;
  logic              pc_bad;
  logic              start_ok;

  assign byte_fire = byte_valid & byte_ready_q;
  assign pc_bad    = (PC_Out[1:0] != '0) || (PC_Out[31:ADDR_W+2] != '0);
  assign start_ok  = start && ((state_q == IDLE) || (state_q == RUN));

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    bcnt_d       = bcnt_q;
    asm_d        = asm_q;
    len_d        = len_q;
    err_d        = err_q;
    done_d       = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;

    unique case (state_q)
      LOAD: begin
        if (byte_fire) begin
          asm_d[{bcnt_q, 3'b000} +: 8] = byte_in;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Write port is registered, so capture the completed word now.
            state_d      = WRITE;
            imem_waddr_d = wptr_q[ADDR_W-1:0];
            imem_wdata_d = asm_d;
          end
        end
      end
      WRITE: begin
        wptr_d = wptr_q + 1'b1;
        if (wptr_d == len_q) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (pc_bad) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (start_ok) begin
      if (len == '0) begin
        state_d = RUN;
        done_d  = 1'b1;
        err_d   = 1'b0;
      end else if (len > DEPTH_W) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        state_d = LOAD;
        len_d   = len;
        wptr_d  = '0;
        bcnt_d  = '0;
        err_d   = 1'b0;
      end
    end

    // Status outputs are decoded from the next state and registered.
    byte_ready_d = (state_d == LOAD);
    cpu_stall_d  = (state_d != RUN);
    imem_we_d    = (state_d == WRITE);
    busy_d       = (state_d == LOAD) || (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      cpu_stall_q  <= 1'b1;
      imem_we_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      len_q        <= len_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      cpu_stall_q  <= cpu_stall_d;
      imem_we_q    <= imem_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign cpu_stall  = cpu_stall_q;
  assign imem_we    = imem_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign imem_raddr = PC_Out[ADDR_W+1:2];

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with an external IMEM model fed by the write port.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  len = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] PC_Out = '0;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [7:0]  imem_raddr;
  logic        cpu_stall;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int wr_count = 0;
  int t0;
  int wc;
  int idx;
  logic [31:0] tb_mem [0:255];
  logic [7:0]  prog [0:7];

  imem_boot_ctrl #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .PC_Out(PC_Out), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .imem_raddr(imem_raddr), .cpu_stall(cpu_stall),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      tb_mem[imem_waddr] <= imem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (imem_we === 1'b1 && cpu_stall === 1'b0) viol++;
  endtask

  task automatic feed(input logic [7:0] b);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!acc && n < 20) begin
      acc = byte_ready;
      step();
      n++;
    end
    chk("feed_accepted", {31'b0, acc}, 32'd1);
  endtask

  initial begin
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'hB3; prog[5] = 8'h82; prog[6] = 8'h31; prog[7] = 8'h40;

    // Reset for two cycles
    rst = 1'b0;
    step(); step();
    chk("rst_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_we",    {31'b0, imem_we}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_err",   {31'b0, err}, 32'd0);
    rst = 1'b1;
    step();

    // Back-to-back load of two words
    t0 = cyc;
    start = 1'b1; len = 9'd2;
    step();
    start = 1'b0;
    chk("t1_ready", {31'b0, byte_ready}, 32'd1);
    chk("t1_busy",  {31'b0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) feed(prog[i]);
    chk("w0_cycle", cyc - t0, 32'd5);
    chk("w0_we",    {31'b0, imem_we}, 32'd1);
    chk("w0_addr",  {24'b0, imem_waddr}, 32'd0);
    chk("w0_data",  imem_wdata, 32'h0000_0013);
    chk("w0_ready", {31'b0, byte_ready}, 32'd0);
    for (int i = 4; i < 8; i++) feed(prog[i]);
    byte_valid = 1'b0;
    chk("w1_cycle", cyc - t0, 32'd10);
    chk("w1_we",    {31'b0, imem_we}, 32'd1);
    chk("w1_addr",  {24'b0, imem_waddr}, 32'd1);
    chk("w1_data",  imem_wdata, 32'h4031_82B3);
    step();
    chk("run_done",  {31'b0, done}, 32'd1);
    chk("run_stall", {31'b0, cpu_stall}, 32'd0);
    chk("run_we",    {31'b0, imem_we}, 32'd0);
    chk("run_busy",  {31'b0, busy}, 32'd0);
    step();
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("mem0", tb_mem[0], 32'h0000_0013);
    chk("mem1", tb_mem[1], 32'h4031_82B3);

    // Same load with byte_valid toggling; bytes land on even cycles
    t0 = cyc;
    idx = 0;
    start = 1'b1; len = 9'd2; byte_valid = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j < 18; j++) begin
      byte_valid = (j % 2 == 0);
      byte_in = prog[idx % 8];
      chk("tg_we", {31'b0, imem_we}, (j == 9 || j == 17) ? 32'd1 : 32'd0);
      if (j == 9) begin
        chk("tg_w0_addr", {24'b0, imem_waddr}, 32'd0);
        chk("tg_w0_data", imem_wdata, 32'h0000_0013);
      end
      if (j == 17) begin
        chk("tg_w1_addr", {24'b0, imem_waddr}, 32'd1);
        chk("tg_w1_data", imem_wdata, 32'h4031_82B3);
      end
      if (byte_valid && byte_ready) idx++;
      step();
    end
    byte_valid = 1'b0;
    chk("tg_bytes", idx, 32'd8);
    chk("tg_done",  {31'b0, done}, 32'd1);
    chk("tg_stall", {31'b0, cpu_stall}, 32'd0);
    chk("tg_cycle", cyc - t0, 32'd18);

    // Oversize length: error, parked in IDLE
    start = 1'b1; len = 9'd257;
    step();
    start = 1'b0;
    chk("big_err",   {31'b0, err}, 32'd1);
    chk("big_stall", {31'b0, cpu_stall}, 32'd1);
    chk("big_busy",  {31'b0, busy}, 32'd0);
    chk("big_ready", {31'b0, byte_ready}, 32'd0);
    wc = wr_count;
    step(); step(); step();
    chk("big_nowr", wr_count, wc);
    chk("big_err_hold", {31'b0, err}, 32'd1);
    t0 = cyc;
    start = 1'b1; len = 9'd1;
    step();
    start = 1'b0;
    chk("one_err_clr", {31'b0, err}, 32'd0);
    chk("one_busy",    {31'b0, busy}, 32'd1);
    feed(8'hEF); feed(8'hBE); feed(8'hAD); feed(8'hDE);
    byte_valid = 1'b0;
    chk("one_cycle", cyc - t0, 32'd5);
    chk("one_we",    {31'b0, imem_we}, 32'd1);
    chk("one_addr",  {24'b0, imem_waddr}, 32'd0);
    chk("one_data",  imem_wdata, 32'hDEAD_BEEF);
    step();
    chk("one_done",  {31'b0, done}, 32'd1);
    chk("one_mem0",  tb_mem[0], 32'hDEAD_BEEF);

    // PC mapping and misaligned / out-of-range PC errors in RUN
    PC_Out = 32'h0000_0014;
    step();
    chk("pc14_raddr", {24'b0, imem_raddr}, 32'd5);
    chk("pc14_err",   {31'b0, err}, 32'd0);
    PC_Out = 32'h0000_0016;
    step();
    chk("pc16_raddr", {24'b0, imem_raddr}, 32'd5);
    chk("pc16_err",   {31'b0, err}, 32'd1);
    chk("pc16_stall", {31'b0, cpu_stall}, 32'd0);
    PC_Out = 32'h0000_0014;
    step();
    chk("err_sticky", {31'b0, err}, 32'd1);
    start = 1'b1; len = 9'd0;
    step();
    start = 1'b0;
    chk("len0_done",  {31'b0, done}, 32'd1);
    chk("len0_err",   {31'b0, err}, 32'd0);
    chk("len0_stall", {31'b0, cpu_stall}, 32'd0);
    chk("len0_busy",  {31'b0, busy}, 32'd0);
    PC_Out = 32'h0000_03FC;
    step();
    chk("pc3fc_raddr", {24'b0, imem_raddr}, 32'd255);
    chk("pc3fc_err",   {31'b0, err}, 32'd0);
    PC_Out = 32'h0000_0400;
    step();
    chk("pc400_raddr", {24'b0, imem_raddr}, 32'd0);
    chk("pc400_err",   {31'b0, err}, 32'd1);
    PC_Out = 32'h0000_0000;

    // Reset in the middle of word 1 of a three-word load
    start = 1'b1; len = 9'd3;
    step();
    start = 1'b0;
    chk("l3_err_clr", {31'b0, err}, 32'd0);
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    chk("l3_w0_data", imem_wdata, 32'h4433_2211);
    feed(8'h55); feed(8'h66);
    byte_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mr_busy",  {31'b0, busy}, 32'd0);
    chk("mr_stall", {31'b0, cpu_stall}, 32'd1);
    chk("mr_ready", {31'b0, byte_ready}, 32'd0);
    chk("mr_we",    {31'b0, imem_we}, 32'd0);
    wc = wr_count;
    byte_in = 8'h77; byte_valid = 1'b1;
    for (int k = 0; k < 8; k++) step();
    byte_valid = 1'b0;
    chk("mr_nowr",  wr_count, wc);
    chk("mr_mem0",  tb_mem[0], 32'h4433_2211);
    chk("mr_stall_hold", {31'b0, cpu_stall}, 32'd1);

    // Full-depth length is accepted
    start = 1'b1; len = 9'd256;
    step();
    start = 1'b0;
    chk("l256_busy",  {31'b0, busy}, 32'd1);
    chk("l256_err",   {31'b0, err}, 32'd0);
    chk("l256_ready", {31'b0, byte_ready}, 32'd1);

    chk("we_vs_stall", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/load controller for the single-cycle core's 256-word instruction memory. Accepts a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into sequential IMEM addresses. It holds the core in stall while loading, then releases it and maps the core's byte-addressed PC onto the IMEM word read address. It replaces hard-coded memory initialisation and arbitrates the single IMEM between loader writes and core fetch.

## Interface
- DEPTH, 256, IMEM depth in words
- ADDR_W, 8, IMEM word-address width; log2(DEPTH)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low; sampled on rising clk
- start  in  1  single-cycle pulse; begins a load of len words
- len  in  ADDR_W+1  word count; latched only on an accepted start
- byte_in  in  8  program byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  controller accepts a byte this cycle
- PC_Out  in  32  core PC, byte address
- imem_we  out  1  IMEM write strobe
- imem_waddr  out  ADDR_W  IMEM write word address
- imem_wdata  out  32  IMEM write data
- imem_raddr  out  ADDR_W  IMEM read word address, always PC_Out[ADDR_W+1:2]
- cpu_stall  out  1  core must hold PC and suppress register/memory writes
- busy  out  1  high in LOAD or WRITE
- done  out  1  one-cycle pulse when a load completes
- err  out  1  sticky error flag; cleared only by reset or an accepted start

## Operation
- States: IDLE, LOAD, WRITE, RUN. Registers: wptr (ADDR_W+1 bits), bcnt (2 bits), asm (32 bits), len_q.
- Reset (rst=0 at a clk edge): state=IDLE, wptr=0, bcnt=0, asm=0, err=0. Outputs: cpu_stall=1, byte_ready=0, imem_we=0, busy=0, done=0, imem_waddr=0, imem_wdata=0.
- Start is accepted in IDLE or RUN:
  - len=0: go to RUN and pulse done. IMEM contents are unchanged.
  - len>DEPTH: set err and go to IDLE. The core stays stalled.
  - 1≤len≤DEPTH: latch len_q, clear wptr, bcnt and err, then go to LOAD.
- A start is ignored in LOAD and WRITE.
- IDLE: cpu_stall=1, byte_ready=0.
- LOAD: byte_ready=1, cpu_stall=1.
  - A byte transfers when byte_valid and byte_ready are both high.
  - Byte k of a word (k=bcnt) is written to asm[8k+7:8k], so the first byte lands in bits [7:0]. Then bcnt increments.
  - When the 4th byte transfers (bcnt=3), go to WRITE.
  - byte_valid low stalls LOAD indefinitely with no timeout.
- WRITE: byte_ready=0, imem_we=1, imem_waddr=wptr[ADDR_W-1:0], imem_wdata=asm, for exactly one cycle.
  - wptr increments.
  - If wptr+1=len_q, go to RUN. Otherwise go to LOAD.
- RUN: cpu_stall=0, byte_ready=0, imem_we=0.
  - If PC_Out[1:0]≠0 or PC_Out[31:ADDR_W+2]≠0 at a clk edge, set err. The core is not stalled by this.
  - An accepted start returns to LOAD with cpu_stall=1 from the next cycle.
- imem_raddr is combinational from PC_Out in every state. The stall makes reads outside RUN harmless.
- Reset mid-load: state returns to IDLE and partial asm is discarded. Words already written stay in IMEM; this block does not clear memory.

## Timing
- start at cycle T: state is LOAD at T+1, and byte_ready is first high at T+1.
- Per word, minimum 5 cycles: 4 byte transfers on consecutive cycles, then 1 WRITE cycle.
- Loading N words with back-to-back bytes takes 5N cycles after start. RUN is entered the cycle after the final WRITE.
- done is high for exactly the first RUN cycle, and cpu_stall falls in that same cycle.
- imem_we must never be high in the same cycle as cpu_stall=0.
- err sets on the clk edge after the offending condition and holds until cleared.
- Outputs other than imem_raddr are registered or decoded from state only. No combinational path from byte_valid to byte_ready.

## Test plan
- Reset with rst=0 for 2 cycles: cpu_stall=1, byte_ready=0, imem_we=0, busy=0, done=0, err=0.
- start with len=2, then bytes 13,00,00,00 and B3,82,31,40 back-to-back:
  - writes 0x00000013 to addr 0 at cycle T+5 and 0x403182B3 to addr 1 at T+10;
  - done pulses at T+11 and cpu_stall=0 from T+11.
- Same load with byte_valid toggled 1/0 every cycle: identical IMEM writes; word 0 write at T+9; no byte lost or duplicated.
- start with len=257: err=1, state IDLE, no imem_we. Then start with len=1: err clears and the load proceeds.
- In RUN with PC_Out=0x00000014: imem_raddr=5, err=0. With PC_Out=0x00000016: err=1 next cycle, stays 1.
- rst=0 after 2 of 4 bytes of word 1 (len=3): state IDLE, cpu_stall=1, no further writes; word 0 remains in IMEM.
